// File: rtl/arb_pkg.sv
// Shared types and widths for the instruction/data memory port arbiter.
// Optional feature macro: ARB_STATS_EN (adds the conflict counter).
package arb_pkg;

  localparam int unsigned WAIT_W  = 4;
  localparam int unsigned COUNT_W = 32;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DRD  = 2'd2
  } owner_e;

  typedef enum logic {
    P_DATA  = 1'b0,
    P_FETCH = 1'b1
  } prio_e;

endpackage

// File: rtl/arb_stats.sv
// Saturating counter of cycles in which both ports requested the RAM.
// Instantiated by mem_port_arbiter only when ARB_STATS_EN is defined.
module arb_stats
  import arb_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               conflict_i,
  output logic [COUNT_W-1:0] count_o
);

  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] count_d;

  // Next count: bump on a conflict, stick at all-ones.
  always_comb begin
    count_d = count_q;
    if (conflict_i && (count_q != {COUNT_W{1'b1}})) begin
      count_d = count_q + COUNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-port (fetch / data) arbiter in front of a single synchronous-read RAM.
// Data wins conflicts until fetch has been denied MAX_WAIT times in a row,
// then fetch wins the next conflict. Read data returns one cycle after grant
// and is routed back to the port recorded in the owner tag.
// Optional feature macro: ARB_STATS_EN (conflict_count becomes a live counter).
module mem_port_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic               if_gnt,
  output logic               if_rvalid,
  output logic [DATA_W-1:0]  if_rdata,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic               d_gnt,
  output logic               d_rvalid,
  output logic [DATA_W-1:0]  d_rdata,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic               mem_we,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic [COUNT_W-1:0] conflict_count
);

  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  prio_e              prio_q, prio_d;
  owner_e             owner_q, owner_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic               conflict_c;

  assign conflict_c = if_req & d_req & ~reset;

  // Grant selection: lone requester wins, otherwise the priority state decides.
  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (if_req && (!d_req || (prio_q == P_FETCH))) begin
        if_gnt = 1'b1;
      end else if (d_req) begin
        d_gnt = 1'b1;
      end
    end
  end

  // Priority FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= P_DATA;
    end else begin
      prio_q <= prio_d;
    end
  end

  // Priority FSM next state: hand priority to fetch once it is starved.
  always_comb begin
    prio_d = prio_q;
    case (prio_q)
      P_DATA: begin
        if (conflict_c && (wait_q == WAIT_LAST)) begin
          prio_d = P_FETCH;
        end
      end
      P_FETCH: begin
        if (if_gnt) begin
          prio_d = P_DATA;
        end
      end
      default: prio_d = P_DATA;
    endcase
  end

  // Next values for the wait counter, owner tag and held RAM address/data.
  always_comb begin
    wait_d = wait_q;
    if (if_gnt) begin
      wait_d = '0;
    end else if (if_req && !reset && (wait_q != {WAIT_W{1'b1}})) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    owner_d = OWN_NONE;
    if (if_gnt) begin
      owner_d = OWN_IF;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_DRD;
    end

    addr_d = addr_q;
    if (if_gnt) begin
      addr_d = if_addr;
    end else if (d_gnt) begin
      addr_d = d_addr;
    end

    wdata_d = wdata_q;
    if (d_gnt) begin
      wdata_d = d_wdata;
    end
  end

  // Datapath and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_q  <= '0;
      owner_q <= OWN_NONE;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      wait_q  <= wait_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign mem_addr  = addr_d;
  assign mem_wdata = wdata_d;
  assign mem_we    = d_gnt & d_we;

  // A reset landing on the return cycle kills the pending read response.
  assign if_rvalid = (owner_q == OWN_IF)  & ~reset;
  assign d_rvalid  = (owner_q == OWN_DRD) & ~reset;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

`ifdef ARB_STATS_EN
  arb_stats u_stats (
    .clk        (clk),
    .reset      (reset),
    .conflict_i (conflict_c),
    .count_o    (conflict_count)
  );
`else
  assign conflict_count = '0;
`endif

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 32, address width; DATA_W, 32, data width; MAX_WAIT, 4, maximum consecutive denied fetch cycles (range 1..15).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 if_req  input  1  instruction-fetch read request, level, held until granted.
REQ-005 if_addr  input  ADDR_W  fetch byte address.
REQ-006 if_gnt  output  1  fetch request accepted this cycle.
REQ-007 if_rvalid  output  1  fetch read data valid.
REQ-008 if_rdata  output  DATA_W  fetch read data.
REQ-009 d_req  input  1  data-port request, level, held until granted.
REQ-010 d_we  input  1  data request is a write.
REQ-011 d_addr  input  ADDR_W  data byte address.
REQ-012 d_wdata  input  DATA_W  store data.
REQ-013 d_gnt  output  1  data request accepted this cycle.
REQ-014 d_rvalid  output  1  load data valid (reads only).
REQ-015 d_rdata  output  DATA_W  load data.
REQ-016 mem_addr  output  ADDR_W  shared RAM address, combinational from the winner.
REQ-017 mem_we  output  1  shared RAM write enable.
REQ-018 mem_wdata  output  DATA_W  shared RAM write data.
REQ-019 mem_rdata  input  DATA_W  RAM read data, one cycle after address (synchronous read).
REQ-020 conflict_count  output  32  cycles with both if_req and d_req high.

Function
REQ-021 At most one of if_gnt/d_gnt SHALL be high per cycle; a grant SHALL be issued combinationally in any cycle with a request.
REQ-022 Single requester SHALL be granted immediately regardless of priority state.
REQ-023 Priority FSM states SHALL be P_DATA (data wins conflicts) and P_FETCH (fetch wins conflicts).
REQ-024 A 4-bit wait counter SHALL increment on each cycle if_req is high and if_gnt low, and clear on if_gnt.
REQ-025 P_DATA -> P_FETCH when a conflict occurs with wait counter == MAX_WAIT-1; P_FETCH -> P_DATA on the cycle if_gnt is asserted.
REQ-026 mem_we SHALL equal d_gnt & d_we; with no grant mem_we SHALL be 0 and mem_addr/mem_wdata hold last values.
REQ-027 A registered owner tag (NONE/IF/DRD) SHALL record each read grant; next cycle if_rvalid or d_rvalid asserts for exactly one cycle with rdata = mem_rdata.
REQ-028 Writes SHALL complete at grant and produce no rvalid.
REQ-029 Back-to-back grants SHALL be sustained at one per cycle; latency grant-to-rvalid SHALL be exactly 1 cycle.
REQ-030 if_rdata/d_rdata SHALL be 0 when the corresponding rvalid is low.

Reset
REQ-031 Reset SHALL force P_DATA, wait counter 0, owner NONE, conflict_count 0, mem_addr/mem_wdata 0.
REQ-032 Reset asserted with a read in flight SHALL suppress the pending rvalid; no grants during reset.

Configuration
REQ-033 With macro ARB_STATS_EN defined, conflict_count SHALL increment (saturating at 0xFFFFFFFF) on each conflict cycle outside reset.
REQ-034 Without ARB_STATS_EN, conflict_count SHALL be constant 0 and no counter register exists.

Structure
REQ-035 Package arb_pkg SHALL hold typedef owner_e (OWN_NONE, OWN_IF, OWN_DRD), typedef prio_e (P_DATA, P_FETCH) and the wait counter width constant.
REQ-036 Sub-module arb_stats (the conflict counter) SHALL be instantiated only under ARB_STATS_EN; all else is inline.

Verification
REQ-037 Fetch-only: if_req=1, if_addr=0x10, mem_rdata=0xDEADBEEF next cycle -> if_gnt same cycle, if_rvalid with if_rdata=0xDEADBEEF one cycle later.
REQ-038 Data store: d_req=1,d_we=1,d_addr=0x200,d_wdata=0x55 -> d_gnt, mem_we=1, mem_wdata=0x55, no d_rvalid.
REQ-039 Sustained conflict, MAX_WAIT=4: both requests held -> d_gnt cycles 0-3, if_gnt cycle 4, d_gnt cycle 5.
REQ-040 Reset pulsed the cycle after a fetch grant -> if_rvalid never asserts; state P_DATA, counters 0.
REQ-041 With ARB_STATS_EN, 10 conflict cycles -> conflict_count=10; without, conflict_count=0.
REQ-042 Alternating load/fetch every cycle -> one grant per cycle, rvalid routed to matching port each following cycle.
